// File: rtl/i2s_tx_sequencer.sv
// Master-mode Philips I2S transmitter. It divides clk_in down to BCLK/LRCLK and
// shifts one stereo PCM pair per frame onto SDATA, MSB first.
module i2s_tx_sequencer #(
  parameter int HALF_DIV   = 4,
  parameter int DATA_WIDTH = 16,
  parameter int SLOT_BITS  = 16
) (
  input  logic                  clk_in,
  input  logic                  ar,
  input  logic                  en,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_left,
  input  logic [DATA_WIDTH-1:0] s_right,
  output logic                  bclk,
  output logic                  lrclk,
  output logic                  sdata,
  output logic                  frame_start,
  output logic                  underrun,
  output logic                  busy
);

  localparam int DIVW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam int PW   = $clog2(2 * SLOT_BITS);
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(HALF_DIV - 1);
  localparam logic [PW-1:0]   P_ZERO   = '0;
  localparam logic [PW-1:0]   P_LAST   = PW'(2 * SLOT_BITS - 1);
  localparam logic [PW-1:0]   P_LR_LO  = PW'(SLOT_BITS - 1);
  localparam logic [PW-1:0]   P_LR_HI  = PW'(2 * SLOT_BITS - 2);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                state_q, state_d;
  logic [DIVW-1:0]       div_q, div_d;
  logic [PW-1:0]         p_q, p_d;
  logic                  bclk_q, bclk_d;
  logic                  lrclk_q, lrclk_d;
  logic                  sdata_q, sdata_d;
  logic                  frame_start_q, frame_start_d;
  logic                  underrun_q, underrun_d;
  logic                  hold_full_q, hold_full_d;
  logic [DATA_WIDTH-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic [DATA_WIDTH-1:0] sh_l_q, sh_l_d, sh_r_q, sh_r_d;
  logic                  do_load;

  // LRCLK leads each slot by one bit, so it spans p = SLOT_BITS-1 .. 2*SLOT_BITS-2.
  function automatic logic lr_of(input logic [PW-1:0] p);
    return (p >= P_LR_LO) && (p <= P_LR_HI);
  endfunction

  function automatic logic slot_bit(input logic [PW-1:0] p,
                                    input logic [DATA_WIDTH-1:0] l,
                                    input logic [DATA_WIDTH-1:0] r);
    int k;
    logic [DATA_WIDTH-1:0] w;
    k = int'(p);
    w = l;
    if (k >= SLOT_BITS) begin
      k = k - SLOT_BITS;
      w = r;
    end
    if (k >= DATA_WIDTH) return 1'b0;
    w = w << k;
    return w[DATA_WIDTH-1];
  endfunction

  // Handshake: a pair transfers on any cycle with s_valid & s_ready, where
  // s_ready = ~hold_full; while s_ready is low the source must hold its data.
  always_comb begin
    state_d       = state_q;
    div_d         = div_q;
    p_d           = p_q;
    bclk_d        = bclk_q;
    lrclk_d       = lrclk_q;
    sdata_d       = sdata_q;
    hold_full_d   = hold_full_q;
    hold_l_d      = hold_l_q;
    hold_r_d      = hold_r_q;
    sh_l_d        = sh_l_q;
    sh_r_d        = sh_r_q;
    frame_start_d = 1'b0;
    underrun_d    = 1'b0;
    do_load       = 1'b0;

    if (s_valid && !hold_full_q) begin
      hold_full_d = 1'b1;
      hold_l_d    = s_left;
      hold_r_d    = s_right;
    end

    case (state_q)
      S_IDLE: begin
        div_d   = '0;
        p_d     = '0;
        bclk_d  = 1'b0;
        lrclk_d = 1'b0;
        sdata_d = 1'b0;
        if (en) begin
          state_d = S_RUN;
          do_load = 1'b1;
        end
      end
      S_RUN: begin
        if (div_q == DIV_LAST) begin
          div_d  = '0;
          bclk_d = ~bclk_q;
          if (bclk_q) begin
            if (p_q == P_LAST) begin
              // Frame boundary: the only point where en is honoured.
              if (en) begin
                do_load = 1'b1;
              end else begin
                state_d = S_IDLE;
                bclk_d  = 1'b0;
                lrclk_d = 1'b0;
                sdata_d = 1'b0;
                p_d     = '0;
              end
            end else begin
              p_d     = p_q + 1'b1;
              lrclk_d = lr_of(p_q + 1'b1);
              sdata_d = slot_bit(p_q + 1'b1, sh_l_q, sh_r_q);
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (do_load) begin
      frame_start_d = 1'b1;
      div_d         = '0;
      p_d           = '0;
      bclk_d        = 1'b0;
      lrclk_d       = lr_of(P_ZERO);
      if (hold_full_q) begin
        sh_l_d      = hold_l_q;
        sh_r_d      = hold_r_q;
        hold_full_d = 1'b0;
      end else if (s_valid) begin
        // Bypass: the pair arriving on the load cycle goes straight out.
        sh_l_d      = s_left;
        sh_r_d      = s_right;
        hold_full_d = 1'b0;
      end else begin
        sh_l_d     = '0;
        sh_r_d     = '0;
        underrun_d = 1'b1;
      end
      sdata_d = slot_bit(P_ZERO, sh_l_d, sh_r_d);
    end
  end

  always_ff @(posedge clk_in) begin
    if (ar) begin
      state_q       <= S_IDLE;
      div_q         <= '0;
      p_q           <= '0;
      bclk_q        <= 1'b0;
      lrclk_q       <= 1'b0;
      sdata_q       <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      hold_full_q   <= 1'b0;
      hold_l_q      <= '0;
      hold_r_q      <= '0;
      sh_l_q        <= '0;
      sh_r_q        <= '0;
    end else begin
      state_q       <= state_d;
      div_q         <= div_d;
      p_q           <= p_d;
      bclk_q        <= bclk_d;
      lrclk_q       <= lrclk_d;
      sdata_q       <= sdata_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
      hold_full_q   <= hold_full_d;
      hold_l_q      <= hold_l_d;
      hold_r_q      <= hold_r_d;
      sh_l_q        <= sh_l_d;
      sh_r_q        <= sh_r_d;
    end
  end

  assign s_ready     = ~hold_full_q;
  assign bclk        = bclk_q;
  assign lrclk       = lrclk_q;
  assign sdata       = sdata_q;
  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;
  assign busy        = (state_q == S_RUN);

endmodule

// File: tb/tb_i2s_tx_sequencer.sv
// Directed bench for i2s_tx_sequencer: a 16-bit-slot instance and a
// 24-bit-slot (zero padded) instance, both at HALF_DIV=2.
module tb_i2s_tx_sequencer;

  logic clk_in = 1'b0;
  logic ar;

  // Instance A: SLOT_BITS=16, 128-cycle frames
  logic        a_en, a_valid, a_ready, a_bclk, a_lrclk, a_sdata, a_fs, a_ur, a_busy;
  logic [15:0] a_left, a_right;
  // Instance P: SLOT_BITS=24, 192-cycle frames
  logic        p_en, p_valid, p_ready, p_bclk, p_lrclk, p_sdata, p_fs, p_ur, p_busy;
  logic [15:0] p_left, p_right;

  logic use_pad;
  logic m_ready, m_bclk, m_lrclk, m_sdata, m_fs, m_ur, m_busy;

  int vectors = 0;
  int miscompares = 0;

  i2s_tx_sequencer #(.HALF_DIV(2), .DATA_WIDTH(16), .SLOT_BITS(16)) u_dut (
    .clk_in(clk_in), .ar(ar), .en(a_en), .s_valid(a_valid), .s_ready(a_ready),
    .s_left(a_left), .s_right(a_right), .bclk(a_bclk), .lrclk(a_lrclk),
    .sdata(a_sdata), .frame_start(a_fs), .underrun(a_ur), .busy(a_busy)
  );

  i2s_tx_sequencer #(.HALF_DIV(2), .DATA_WIDTH(16), .SLOT_BITS(24)) u_pad (
    .clk_in(clk_in), .ar(ar), .en(p_en), .s_valid(p_valid), .s_ready(p_ready),
    .s_left(p_left), .s_right(p_right), .bclk(p_bclk), .lrclk(p_lrclk),
    .sdata(p_sdata), .frame_start(p_fs), .underrun(p_ur), .busy(p_busy)
  );

  assign m_ready = use_pad ? p_ready : a_ready;
  assign m_bclk  = use_pad ? p_bclk  : a_bclk;
  assign m_lrclk = use_pad ? p_lrclk : a_lrclk;
  assign m_sdata = use_pad ? p_sdata : a_sdata;
  assign m_fs    = use_pad ? p_fs    : a_fs;
  assign m_ur    = use_pad ? p_ur    : a_ur;
  assign m_busy  = use_pad ? p_busy  : a_busy;

  // Clock / reset
  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Runs n cycles, collecting sdata at each bclk rise and noting at which
  // bit count lrclk rose/fell. Drops a_en after tick index drop_at.
  task automatic watch(input int n, input int drop_at,
                       output logic [63:0] bits, output int rises,
                       output int fs, output int ur, output int rdy_lo,
                       output int lr_up, output int lr_dn);
    logic pb, pl;
    bits = '0; rises = 0; fs = 0; ur = 0; rdy_lo = 0; lr_up = -1; lr_dn = -1;
    pb = m_bclk;
    pl = m_lrclk;
    for (int i = 0; i < n; i++) begin
      tick();
      if (i == drop_at) a_en = 1'b0;
      if (m_bclk && !pb) begin
        bits = {bits[62:0], m_sdata};
        rises++;
      end
      if (m_lrclk && !pl) lr_up = rises;
      if (!m_lrclk && pl) lr_dn = rises;
      if (m_fs) fs++;
      if (m_ur) ur++;
      if (!m_ready) rdy_lo++;
      pb = m_bclk;
      pl = m_lrclk;
    end
  endtask

  task automatic check_load(input string tag, input logic ur_exp,
                            input logic sd_exp, input logic rdy_exp);
    check({tag, "_fs"},    64'(m_fs),    64'd1);
    check({tag, "_ur"},    64'(m_ur),    64'(ur_exp));
    check({tag, "_busy"},  64'(m_busy),  64'd1);
    check({tag, "_sdata"}, 64'(m_sdata), 64'(sd_exp));
    check({tag, "_ready"}, 64'(m_ready), 64'(rdy_exp));
  endtask

  logic [63:0] bits;
  int rises, fs, ur, rdy_lo, lr_up, lr_dn;

  initial begin
    use_pad = 1'b0;
    ar = 1'b1;
    a_en = 1'b0; a_valid = 1'b0; a_left = '0; a_right = '0;
    p_en = 1'b0; p_valid = 1'b0; p_left = '0; p_right = '0;
    tick();
    tick();
    ar = 1'b0;
    check("rst_bclk",  64'(a_bclk),  64'd0);
    check("rst_lrclk", 64'(a_lrclk), 64'd0);
    check("rst_sdata", 64'(a_sdata), 64'd0);
    check("rst_fs",    64'(a_fs),    64'd0);
    check("rst_ur",    64'(a_ur),    64'd0);
    check("rst_busy",  64'(a_busy),  64'd0);
    check("rst_ready", 64'(a_ready), 64'd1);

    // Pre-fill the holding buffer while idle
    a_valid = 1'b1; a_left = 16'hA5C3; a_right = 16'h3C5A;
    tick();
    a_valid = 1'b0;
    check("idle_ready", 64'(a_ready), 64'd0);
    check("idle_bclk",  64'(a_bclk),  64'd0);
    check("idle_busy",  64'(a_busy),  64'd0);

    // Frame 1: A5C3/3C5A from hold
    a_en = 1'b1;
    tick();
    check_load("f1", 1'b0, 1'b1, 1'b1);
    a_valid = 1'b1; a_left = 16'h1234; a_right = 16'h5678;
    tick();
    check("f1_hold_ready", 64'(a_ready), 64'd0);
    a_left = 16'hDEAD; a_right = 16'hBEEF;   // next pair waits under backpressure
    watch(126, -1, bits, rises, fs, ur, rdy_lo, lr_up, lr_dn);
    check("f1_bits",   bits,          64'h0000_0000_A5C3_3C5A);
    check("f1_rises",  64'(rises),    64'd32);
    check("f1_lr_up",  64'(lr_up),    64'd15);
    check("f1_lr_dn",  64'(lr_dn),    64'd31);
    check("f1_fs",     64'(fs),       64'd0);
    check("f1_ur",     64'(ur),       64'd0);
    check("f1_rdy_lo", 64'(rdy_lo),   64'd126);

    // Frame 2: 1234/5678 from hold; DEAD/BEEF accepted one cycle later
    tick();
    check_load("f2", 1'b0, 1'b0, 1'b1);
    tick();
    check("f2_accept_ready", 64'(a_ready), 64'd0);
    a_valid = 1'b0;
    watch(126, -1, bits, rises, fs, ur, rdy_lo, lr_up, lr_dn);
    check("f2_bits", bits, 64'h0000_0000_1234_5678);
    check("f2_ur",   64'(ur), 64'd0);

    // Frame 3: DEAD/BEEF from hold
    tick();
    check_load("f3", 1'b0, 1'b1, 1'b1);
    watch(127, -1, bits, rises, fs, ur, rdy_lo, lr_up, lr_dn);
    check("f3_bits", bits, 64'h0000_0000_DEAD_BEEF);

    // Frame 4: nothing available -> underrun, silent frame
    tick();
    check_load("f4", 1'b1, 1'b0, 1'b1);
    watch(127, -1, bits, rises, fs, ur, rdy_lo, lr_up, lr_dn);
    check("f4_bits",   bits,        64'h0);
    check("f4_rdy_lo", 64'(rdy_lo), 64'd0);
    check("f4_ur",     64'(ur),     64'd0);

    // Frame 5: bypass on the boundary cycle, then graceful stop at p=5
    a_valid = 1'b1; a_left = 16'h8001; a_right = 16'h7FFE;
    tick();
    check_load("f5", 1'b0, 1'b1, 1'b1);
    a_left = 16'h1357; a_right = 16'h2468;
    tick();
    check("f5_hold_ready", 64'(a_ready), 64'd0);
    a_valid = 1'b0;
    watch(126, 18, bits, rises, fs, ur, rdy_lo, lr_up, lr_dn);
    check("f5_bits",      bits,        64'h0000_0000_8001_7FFE);
    check("f5_busy_end",  64'(a_busy), 64'd1);
    tick();
    check("stop_busy",  64'(a_busy),  64'd0);
    check("stop_bclk",  64'(a_bclk),  64'd0);
    check("stop_lrclk", 64'(a_lrclk), 64'd0);
    check("stop_sdata", 64'(a_sdata), 64'd0);
    check("stop_fs",    64'(a_fs),    64'd0);
    check("stop_ur",    64'(a_ur),    64'd0);
    check("stop_ready", 64'(a_ready), 64'd0);
    watch(4, -1, bits, rises, fs, ur, rdy_lo, lr_up, lr_dn);
    check("idle_rises", 64'(rises), 64'd0);
    check("idle_fs",    64'(fs),    64'd0);

    // Restart with held 1357/2468, then reset at p=10 while bclk is high
    a_en = 1'b1;
    tick();
    check_load("f6", 1'b0, 1'b0, 1'b1);
    a_valid = 1'b1; a_left = 16'hAAAA; a_right = 16'h5555;
    tick();
    a_valid = 1'b0;
    repeat (41) tick();
    check("pre_rst_bclk",  64'(a_bclk),  64'd1);
    check("pre_rst_ready", 64'(a_ready), 64'd0);
    ar = 1'b1;
    tick();
    ar = 1'b0;
    check("mid_rst_bclk",  64'(a_bclk),  64'd0);
    check("mid_rst_lrclk", 64'(a_lrclk), 64'd0);
    check("mid_rst_sdata", 64'(a_sdata), 64'd0);
    check("mid_rst_fs",    64'(a_fs),    64'd0);
    check("mid_rst_busy",  64'(a_busy),  64'd0);
    check("mid_rst_ready", 64'(a_ready), 64'd1);
    tick();
    check_load("f7", 1'b1, 1'b0, 1'b1);
    watch(127, -1, bits, rises, fs, ur, rdy_lo, lr_up, lr_dn);
    check("f7_rises", 64'(rises), 64'd32);
    check("f7_lr_up", 64'(lr_up), 64'd15);
    check("f7_lr_dn", 64'(lr_dn), 64'd31);
    check("f7_bits",  bits,       64'h0);
    tick();
    check("f8_period_fs", 64'(a_fs), 64'd1);
    a_en = 1'b0;

    // Padding: 24-bit slots carrying 16-bit samples
    use_pad = 1'b1;
    p_valid = 1'b1; p_left = 16'hFFFF; p_right = 16'h0001;
    tick();
    p_valid = 1'b0;
    p_en = 1'b1;
    tick();
    check_load("pad", 1'b0, 1'b1, 1'b1);
    watch(191, -1, bits, rises, fs, ur, rdy_lo, lr_up, lr_dn);
    check("pad_bits",  bits,        64'h0000_FFFF_0000_0100);
    check("pad_rises", 64'(rises),  64'd48);
    check("pad_lr_up", 64'(lr_up),  64'd23);
    check("pad_lr_dn", 64'(lr_dn),  64'd47);
    check("pad_fs",    64'(fs),     64'd0);
    tick();
    check("pad_period_fs", 64'(p_fs), 64'd1);
    check("pad_period_ur", 64'(p_ur), 64'd1);
    p_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/i2s_tx_sequencer.md
Name: i2s_tx_sequencer

Overview:
- Master-mode I2S transmit controller. Derives BCLK and LRCLK from the system clock and sequences stereo PCM samples onto SDATA in Philips I2S format.
- Accepts left/right sample pairs through a one-deep valid/ready buffer.
- Sits between the audio sample source and the DE2 codec serial pins, all in the clk_in domain.

Parameters:
- HALF_DIV, 4, clk_in cycles per BCLK half-period (>=1). Default gives BCLK = clk_in/8.
- DATA_WIDTH, 16, PCM sample width in bits.
- SLOT_BITS, 16, BCLK periods per channel slot (>= DATA_WIDTH). One frame is 2*SLOT_BITS bits.

Ports:
- clk_in input 1: system clock; all logic on its rising edge.
- ar input 1: synchronous reset, active-high.
- en input 1: run request.
- s_valid input 1: sample pair valid.
- s_ready output 1: holding buffer empty.
- s_left input DATA_WIDTH: left sample.
- s_right input DATA_WIDTH: right sample.
- bclk output 1: serial bit clock (registered).
- lrclk output 1: word select; 0 = left, 1 = right (registered).
- sdata output 1: serial data, MSB first (registered).
- frame_start output 1: one-cycle pulse when a frame is loaded.
- underrun output 1: one-cycle pulse, coincident with frame_start, when no sample was available.
- busy output 1: high while in RUN.

Behaviour:
- Reset (ar high on a clk_in edge):
  - state IDLE; divider count and bit index 0.
  - Holding buffer empty; shift registers 0.
  - bclk=0, lrclk=0, sdata=0, frame_start=0, underrun=0, busy=0, s_ready=1.
  - ar asserted mid-frame aborts the frame immediately; no completion.
- Handshake:
  - s_ready = ~hold_full.
  - Transfer occurs when s_valid & s_ready; the pair is stored and hold_full is set.
  - s_valid while s_ready=0 is ignored; the source must hold its data.
- States: IDLE and RUN.
  - IDLE: divider stopped; bclk, lrclk and sdata held at 0.
  - IDLE -> RUN on any cycle with en=1. That cycle performs a frame load, bit index=0, divider=0, busy=1.
- Divider:
  - Counter runs 0..HALF_DIV-1; at HALF_DIV-1 it wraps and bclk toggles.
  - A falling event is a toggle while bclk=1.
  - bclk first rises HALF_DIV cycles after the load cycle.
- Bit index p (0..2*SLOT_BITS-1):
  - Increments on each falling event.
  - Wraps from 2*SLOT_BITS-1 to 0; that wrap event is the frame boundary.
- lrclk:
  - 1 exactly while p is in [SLOT_BITS-1, 2*SLOT_BITS-2], else 0.
  - Changes only on falling events, so it leads the slot's MSB by one bit.
- sdata:
  - Updates on falling events and at load; stable across every bclk rising edge.
  - p < SLOT_BITS: left slot bit p.
  - p >= SLOT_BITS: right slot bit p-SLOT_BITS.
  - Slot bit k is sample bit DATA_WIDTH-1-k for k < DATA_WIDTH, else 0 (zero pad).
- Frame load (RUN entry or frame boundary with en=1):
  - If hold_full: shift regs take the held pair, hold_full clears.
  - Else if s_valid in the same cycle: bypass; the incoming pair loads directly, hold stays empty, no underrun.
  - Else: shift regs load zeros and underrun pulses.
  - frame_start pulses for 1 cycle on every load.
- Stop:
  - en is sampled only at frame boundaries; dropping en mid-frame has no effect until the boundary.
  - Boundary with en=0: go IDLE that cycle; bclk, lrclk, sdata, busy -> 0; no load, no pulses.
  - A held sample survives in the buffer for the next run.
- Latency:
  - Load cycle drives the left MSB on sdata (registered, visible next cycle).
  - MSB of a frame is sampled by the codec at the first bclk rise, HALF_DIV cycles after load.
- Frame period: 4*HALF_DIV*SLOT_BITS clk_in cycles.

Test Plan:
- Basic frame (HALF_DIV=2, DATA_WIDTH=16, SLOT_BITS=16): pair 0xA5C3/0x3C5A held, en=1 -> 128-cycle frames; frame_start period 128; sampled bits at bclk rises = A5C3 then 3C5A; lrclk rises at p=15, falls at p=31; underrun never pulses.
- Underrun: RUN with s_valid=0 at a boundary -> underrun and frame_start pulse together; sdata all zero that frame; s_ready stays 1.
- Bypass/backpressure: hold full, s_valid=1 -> s_ready=0 until next boundary, then the held pair transmits and s_ready=1; empty hold with s_valid=1 exactly on the boundary cycle -> that pair transmits and underrun=0.
- Padding (SLOT_BITS=24, DATA_WIDTH=16): left 0xFFFF -> 16 ones then 8 zeros per slot; frame period 192 cycles at HALF_DIV=2.
- Graceful stop: en dropped at p=5 -> frame completes through p=31; at the boundary busy=0, bclk=lrclk=sdata=0; a held pair remains and s_ready=0.
- Reset mid-frame: ar=1 at p=10 -> next cycle all outputs at reset values, s_ready=1; en=1 afterwards restarts at p=0 with frame_start.
